exu_wb_arb: RTL and testbench
=============================

Name: exu_wb_arb

Overview:
- Writeback arbiter directly downstream of the 3-stage multiplier and the single-cycle ALU.
- Merges both result streams onto the one register-file write port and retires instruction tag/encoding for trace.
- Multiplier results have fixed latency and no backpressure, so they always win the port.
- Colliding ALU results are held in an in-order skid FIFO, and the block back-pressures ALU issue when that FIFO nears full.

Parameters:
- XLEN, 32, datapath width (shared global constant)
- ALU_Q_DEPTH, 4, ALU skid FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- freeze  in  1  pipeline freeze; holds ALU FIFO pop and age counters
- alu_out  in  XLEN  ALU result
- alu_rd_addr  in  5  ALU destination
- alu_rd_wr_en  in  1  ALU result valid
- alu_instr_tag  in  XLEN  ALU instruction tag
- alu_instr  in  32  ALU instruction encoding
- mul_out  in  XLEN  multiplier result
- mul_rd_addr  in  5  multiplier destination
- mul_rd_wr_en  in  1  multiplier result valid
- mul_instr_tag  in  XLEN  multiplier instruction tag
- mul_instr  in  32  multiplier instruction encoding
- wb_valid  out  1  an instruction retires this cycle
- wb_rd_wr_en  out  1  register-file write enable
- wb_rd_addr  out  5  register-file write address
- wb_rd_data  out  XLEN  register-file write data
- wb_instr_tag  out  XLEN  retiring tag
- wb_instr  out  32  retiring encoding
- alu_stall  out  1  upstream must not issue a new ALU op
- wb_ovf_err  out  1  sticky: ALU push attempted while FIFO full

Behaviour:
- Reset value of every output is 0. Reset clears the FIFO, pointers, count and wb_ovf_err; it is asynchronous and effective mid-operation, and in-flight FIFO contents are discarded.
- Output stage is registered: the result selected in cycle t appears on wb_* in cycle t+1. Fixed latency is 1 for multiplier results, and 1 for ALU results when the FIFO is empty and there is no collision.
- Selection priority each cycle:
  1. mul_rd_wr_en.
  2. Otherwise the FIFO head, if the FIFO is non-empty and ~freeze.
  3. Otherwise alu_rd_wr_en directly (bypass), only when the FIFO is empty.
- Enqueue: alu_rd_wr_en is pushed when it is not selected, i.e. mul is active, the FIFO is non-empty, or freeze=1. Simultaneous push and pop in the same cycle is allowed; count is unchanged.
- A multiplier result is never delayed by freeze, because the multiplier data path does not stop.
- Each FIFO entry holds {data, rd_addr, wr_en, tag, instr, age[1:0]}.
  - age=0 on push; increments, saturating at 3, each cycle the entry stays resident with ~freeze.
  - Entries with age≥2 were issued before any multiplier op now retiring.
- Stale-write kill: when a mul write commits to rd R, every resident entry with age≥2, wr_en=1 and rd_addr==R has its wr_en cleared. The entry still retires with wb_valid=1 and wb_rd_wr_en=0.
- x0: rd_addr==0 forces wb_rd_wr_en=0 but keeps wb_valid=1.
- alu_stall = (count ≥ ALU_Q_DEPTH-1). Registered, so it covers the one op already in flight.
- Full plus push: entry dropped, wb_ovf_err set until reset. This is an error case only.
- Empty FIFO with no inputs: wb_valid=0, and wb_* data hold their previous values. Verification ignores the data fields when wb_valid=0.
- Wrap-around: pointers are log2(ALU_Q_DEPTH) bits and wrap naturally; count is one bit wider.

Decomposition:
- Shared types package gets wb_entry_t (data, rd_addr, wr_en, tag, instr, age) and a wb_src_e enum {WB_NONE, WB_MUL, WB_ALUQ, WB_ALU}.
- One sub-module, exu_wb_fifo: parameterised sync FIFO with push/pop/count and a per-entry kill vector input. The kill/age logic stays in the parent.
- Flops use the existing dff_rst / dff_rst_en cells.

Test Plan:
- ALU only: alu op rd=5, data=0x11 at cycle 0 → cycle 1 wb_valid=1, wb_rd_wr_en=1, rd=5, data=0x11; alu_stall stays 0.
- Collision: mul rd=3, data=0xAAAA and alu rd=4, data=0x22 in the same cycle → cycle+1 mul write, cycle+2 ALU write; count peaks at 1.
- Stale kill: alu rd=7 buffered behind 3 back-to-back mul writes (rd 1, 2, 7) → ALU entry retires after the rd=7 mul write with wb_valid=1, wb_rd_wr_en=0.
- Backpressure/overflow (DEPTH=4): mul busy every cycle while alu pushes each cycle → alu_stall=1 once count=3. Forcing a 5th push sets wb_ovf_err=1 and the entry is lost.
- Freeze: FIFO holds 2 entries, freeze=1 for 3 cycles while a mul result arrives → mul write passes; no ALU pop; ages unchanged; entries drain in order after release.
- Reset mid-drain: rst_n low with count=2 → all outputs 0 immediately, count=0, no further wb_valid after release.

Source files
------------

// File: rtl/exu_wb_arb_pkg.sv
//==============================================================================
// exu_wb_arb_pkg : shared types for the execute-unit writeback arbiter
// Rev 1.0
//==============================================================================
`default_nettype none

package exu_wb_arb_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [4:0]      rd_addr;
        logic            wr_en;
        logic [XLEN-1:0] tag;
        logic [31:0]     instr;
        logic [1:0]      age;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_MUL  = 2'd1,
        WB_ALUQ = 2'd2,
        WB_ALU  = 2'd3
    } wb_src_e;

endpackage

`default_nettype wire

// File: rtl/exu_wb_fifo.sv
//==============================================================================
// exu_wb_fifo : in-order ALU skid FIFO with per-entry write-kill and age update
// Rev 1.0
//==============================================================================
`default_nettype none

module exu_wb_fifo
    import exu_wb_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_push,
    input  wb_entry_t                       i_push_entry,
    input  logic                            i_pop,
    input  logic [DEPTH-1:0]                i_kill,
    input  logic [DEPTH-1:0][1:0]           i_age_next,
    output wb_entry_t [DEPTH-1:0]           o_mem,
    output logic [DEPTH-1:0]                o_occ,
    output logic [$clog2(DEPTH)-1:0]        o_head_idx,
    output logic [$clog2(DEPTH):0]          o_count,
    output logic                            o_empty,
    output logic                            o_ovf
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    wb_entry_t [DEPTH-1:0] r_mem;
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_CW-1:0]       r_count;

    logic w_full;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_full    = (r_count == c_CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign w_push_ok = i_push & (~w_full | w_pop_ok);
    assign o_ovf     = i_push & ~w_push_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i].wr_en <= r_mem[i].wr_en & ~i_kill[i];
                r_mem[i].age   <= i_age_next[i];
            end
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_push_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_CW'(w_push_ok) - c_CW'(w_pop_ok);
        end
    end

    // A slot is resident when its distance from the read pointer is below count.
    always_comb begin
        o_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_occ[i] = ({1'b0, c_AW'(i) - r_rd_ptr} < r_count);
        end
    end

    assign o_mem      = r_mem;
    assign o_head_idx = r_rd_ptr;
    assign o_count    = r_count;

endmodule

`default_nettype wire

// File: rtl/exu_wb_arb.sv
//==============================================================================
// exu_wb_arb : merges multiplier and ALU results onto the register-file port
// Rev 1.0
//==============================================================================
`default_nettype none

module exu_wb_arb
    import exu_wb_arb_pkg::*;
#(
    parameter int ALU_Q_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_freeze,
    input  logic [XLEN-1:0] i_alu_out,
    input  logic [4:0]      i_alu_rd_addr,
    input  logic            i_alu_rd_wr_en,
    input  logic [XLEN-1:0] i_alu_instr_tag,
    input  logic [31:0]     i_alu_instr,
    input  logic [XLEN-1:0] i_mul_out,
    input  logic [4:0]      i_mul_rd_addr,
    input  logic            i_mul_rd_wr_en,
    input  logic [XLEN-1:0] i_mul_instr_tag,
    input  logic [31:0]     i_mul_instr,
    output logic            o_wb_valid,
    output logic            o_wb_rd_wr_en,
    output logic [4:0]      o_wb_rd_addr,
    output logic [XLEN-1:0] o_wb_rd_data,
    output logic [XLEN-1:0] o_wb_instr_tag,
    output logic [31:0]     o_wb_instr,
    output logic            o_alu_stall,
    output logic            o_wb_ovf_err
);

    localparam int c_AW = $clog2(ALU_Q_DEPTH);
    localparam int c_CW = c_AW + 1;

    wb_src_e                     w_src;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_ovf_push;
    logic                        w_empty;
    logic [ALU_Q_DEPTH-1:0]      w_kill;
    logic [ALU_Q_DEPTH-1:0][1:0] w_age_next;
    wb_entry_t [ALU_Q_DEPTH-1:0] w_mem;
    logic [ALU_Q_DEPTH-1:0]      w_occ;
    logic [c_AW-1:0]             w_head_idx;
    logic [c_CW-1:0]             w_count;
    wb_entry_t                   w_alu_entry;

    logic [XLEN-1:0]             w_sel_data;
    logic [4:0]                  w_sel_rd;
    logic                        w_sel_we;
    logic [XLEN-1:0]             w_sel_tag;
    logic [31:0]                 w_sel_instr;

    logic                        r_valid;
    logic                        r_wr_en;
    logic [4:0]                  r_rd_addr;
    logic [XLEN-1:0]             r_data;
    logic [XLEN-1:0]             r_tag;
    logic [31:0]                 r_instr;
    logic                        r_ovf;

    // Multiplier never stalls; a frozen or non-empty queue forces ALU results to queue.
    always_comb begin
        w_src = WB_NONE;
        if (i_mul_rd_wr_en) begin
            w_src = WB_MUL;
        end else if (!w_empty && !i_freeze) begin
            w_src = WB_ALUQ;
        end else if (i_alu_rd_wr_en && w_empty && !i_freeze) begin
            w_src = WB_ALU;
        end
    end

    assign w_push = i_alu_rd_wr_en & (w_src != WB_ALU);
    assign w_pop  = (w_src == WB_ALUQ);

    always_comb begin
        w_alu_entry         = '0;
        w_alu_entry.data    = i_alu_out;
        w_alu_entry.rd_addr = i_alu_rd_addr;
        w_alu_entry.wr_en   = i_alu_rd_wr_en;
        w_alu_entry.tag     = i_alu_instr_tag;
        w_alu_entry.instr   = i_alu_instr;
    end

    // Entries aged two or more predate the retiring multiplier op, so its write supersedes them.
    always_comb begin
        w_kill     = '0;
        w_age_next = '0;
        for (int i = 0; i < ALU_Q_DEPTH; i++) begin
            w_kill[i] = i_mul_rd_wr_en & w_occ[i] & w_mem[i].wr_en & w_mem[i].age[1] &
                        (w_mem[i].rd_addr == i_mul_rd_addr);
            w_age_next[i] = (!i_freeze && (w_mem[i].age != 2'd3)) ? w_mem[i].age + 2'd1
                                                                   : w_mem[i].age;
        end
    end

    exu_wb_fifo #(
        .DEPTH        (ALU_Q_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_entry (w_alu_entry),
        .i_pop        (w_pop),
        .i_kill       (w_kill),
        .i_age_next   (w_age_next),
        .o_mem        (w_mem),
        .o_occ        (w_occ),
        .o_head_idx   (w_head_idx),
        .o_count      (w_count),
        .o_empty      (w_empty),
        .o_ovf        (w_ovf_push)
    );

    always_comb begin
        w_sel_data  = '0;
        w_sel_rd    = '0;
        w_sel_we    = 1'b0;
        w_sel_tag   = '0;
        w_sel_instr = '0;
        case (w_src)
            WB_MUL: begin
                w_sel_data  = i_mul_out;
                w_sel_rd    = i_mul_rd_addr;
                w_sel_we    = 1'b1;
                w_sel_tag   = i_mul_instr_tag;
                w_sel_instr = i_mul_instr;
            end
            WB_ALUQ: begin
                w_sel_data  = w_mem[w_head_idx].data;
                w_sel_rd    = w_mem[w_head_idx].rd_addr;
                w_sel_we    = w_mem[w_head_idx].wr_en;
                w_sel_tag   = w_mem[w_head_idx].tag;
                w_sel_instr = w_mem[w_head_idx].instr;
            end
            WB_ALU: begin
                w_sel_data  = i_alu_out;
                w_sel_rd    = i_alu_rd_addr;
                w_sel_we    = 1'b1;
                w_sel_tag   = i_alu_instr_tag;
                w_sel_instr = i_alu_instr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_addr <= '0;
            r_data    <= '0;
            r_tag     <= '0;
            r_instr   <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_valid <= (w_src != WB_NONE);
            r_ovf   <= r_ovf | w_ovf_push;
            if (w_src != WB_NONE) begin
                r_wr_en   <= w_sel_we & (w_sel_rd != 5'd0);
                r_rd_addr <= w_sel_rd;
                r_data    <= w_sel_data;
                r_tag     <= w_sel_tag;
                r_instr   <= w_sel_instr;
            end else begin
                r_wr_en   <= 1'b0;
            end
        end
    end

    assign o_wb_valid     = r_valid;
    assign o_wb_rd_wr_en  = r_wr_en;
    assign o_wb_rd_addr   = r_rd_addr;
    assign o_wb_rd_data   = r_data;
    assign o_wb_instr_tag = r_tag;
    assign o_wb_instr     = r_instr;
    assign o_wb_ovf_err   = r_ovf;
    // Count is itself a flop; stalling one entry early covers the op already issued.
    assign o_alu_stall    = (w_count >= c_CW'(ALU_Q_DEPTH - 1));

endmodule

`default_nettype wire

// File: tb/tb_exu_wb_arb.sv
//==============================================================================
// tb_exu_wb_arb : directed and random checks against a queue-based model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_exu_wb_arb;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        freeze;
    logic [31:0] alu_out, alu_tag, alu_instr;
    logic [4:0]  alu_rd;
    logic        alu_we;
    logic [31:0] mul_out, mul_tag, mul_instr;
    logic [4:0]  mul_rd;
    logic        mul_we;
    logic        wb_valid, wb_we, alu_stall, ovf_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, wb_tag, wb_instr;

    exu_wb_arb #(.ALU_Q_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_freeze        (freeze),
        .i_alu_out       (alu_out),
        .i_alu_rd_addr   (alu_rd),
        .i_alu_rd_wr_en  (alu_we),
        .i_alu_instr_tag (alu_tag),
        .i_alu_instr     (alu_instr),
        .i_mul_out       (mul_out),
        .i_mul_rd_addr   (mul_rd),
        .i_mul_rd_wr_en  (mul_we),
        .i_mul_instr_tag (mul_tag),
        .i_mul_instr     (mul_instr),
        .o_wb_valid      (wb_valid),
        .o_wb_rd_wr_en   (wb_we),
        .o_wb_rd_addr    (wb_rd),
        .o_wb_rd_data    (wb_data),
        .o_wb_instr_tag  (wb_tag),
        .o_wb_instr      (wb_instr),
        .o_alu_stall     (alu_stall),
        .o_wb_ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] tag;
        logic [31:0] instr;
        int          age;
    } ent_t;

    ent_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        e_valid, e_we, e_stall, e_ovf;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_tag, e_instr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: mul wins; else queue head unless frozen; else bypass when queue empty.
    task automatic step(input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                        input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit frz);
        ent_t m, a, s;
        bit   sel, used;
        @(negedge clk);
        m.data = md; m.rd = mrd; m.we = 1'b1; m.tag = $urandom; m.instr = $urandom; m.age = 0;
        a.data = ad; a.rd = ard; a.we = 1'b1; a.tag = $urandom; a.instr = $urandom; a.age = 0;
        mul_we = mv; mul_rd = mrd; mul_out = md; mul_tag = m.tag; mul_instr = m.instr;
        alu_we = av; alu_rd = ard; alu_out = ad; alu_tag = a.tag; alu_instr = a.instr;
        freeze = frz;
        sel = 0; used = 0; s = m;
        if (mv) begin
            sel = 1; s = m;
            foreach (q[i]) if (q[i].age >= 2 && q[i].we && q[i].rd == mrd) q[i].we = 1'b0;
        end else if (q.size() > 0 && !frz) begin
            sel = 1; s = q.pop_front();
        end else if (av && !frz) begin
            sel = 1; s = a; used = 1;
        end
        if (!frz) foreach (q[i]) if (q[i].age < 3) q[i].age++;
        if (av && !used) begin
            if (q.size() < DEPTH) q.push_back(a);
            else e_ovf = 1'b1;
        end
        e_valid = sel;
        e_we    = sel && s.we && (s.rd != 5'd0);
        if (sel) begin
            e_rd = s.rd; e_data = s.data; e_tag = s.tag; e_instr = s.instr;
        end
        e_stall = (q.size() >= DEPTH - 1);
        @(posedge clk);
        #1;
        chk("wb_valid", 64'(wb_valid), 64'(e_valid));
        chk("wb_rd_wr_en", 64'(wb_we), 64'(e_we));
        chk("alu_stall", 64'(alu_stall), 64'(e_stall));
        chk("wb_ovf_err", 64'(ovf_err), 64'(e_ovf));
        if (e_valid) begin
            chk("wb_rd_addr", 64'(wb_rd), 64'(e_rd));
            chk("wb_rd_data", 64'(wb_data), 64'(e_data));
            chk("wb_instr_tag", 64'(wb_tag), 64'(e_tag));
            chk("wb_instr", 64'(wb_instr), 64'(e_instr));
        end
    endtask

    task automatic idle();
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(wb_valid), 64'd0);
        chk({tag, "_we"}, 64'(wb_we), 64'd0);
        chk({tag, "_rd"}, 64'(wb_rd), 64'd0);
        chk({tag, "_data"}, 64'(wb_data), 64'd0);
        chk({tag, "_tag"}, 64'(wb_tag), 64'd0);
        chk({tag, "_instr"}, 64'(wb_instr), 64'd0);
        chk({tag, "_stall"}, 64'(alu_stall), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf_err), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; freeze = 1'b0;
        alu_we = 1'b0; alu_rd = '0; alu_out = '0; alu_tag = '0; alu_instr = '0;
        mul_we = 1'b0; mul_rd = '0; mul_out = '0; mul_tag = '0; mul_instr = '0;
        e_valid = 0; e_we = 0; e_stall = 0; e_ovf = 0;
        e_rd = '0; e_data = '0; e_tag = '0; e_instr = '0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ALU only, bypass path
        step(0, 5'd0, 32'd0, 1, 5'd5, 32'h11, 0);
        chk("alu_only_rd", 64'(wb_rd), 64'd5);
        chk("alu_only_data", 64'(wb_data), 64'h11);
        chk("alu_only_we", 64'(wb_we), 64'd1);
        idle();

        // Collision: mul first, ALU one cycle later
        step(1, 5'd3, 32'hAAAA, 1, 5'd4, 32'h22, 0);
        chk("coll_mul_rd", 64'(wb_rd), 64'd3);
        chk("coll_mul_data", 64'(wb_data), 64'hAAAA);
        idle();
        chk("coll_alu_rd", 64'(wb_rd), 64'd4);
        chk("coll_alu_data", 64'(wb_data), 64'h22);
        idle();

        // Stale kill: ALU rd=7 held behind mul writes rd 1, 2, 7
        step(1, 5'd10, 32'h1010, 1, 5'd7, 32'h77, 0);
        step(1, 5'd1, 32'h0101, 0, 5'd0, 32'd0, 0);
        step(1, 5'd2, 32'h0202, 0, 5'd0, 32'd0, 0);
        step(1, 5'd7, 32'h0707, 0, 5'd0, 32'd0, 0);
        idle();
        chk("kill_valid", 64'(wb_valid), 64'd1);
        chk("kill_rd", 64'(wb_rd), 64'd7);
        chk("kill_we", 64'(wb_we), 64'd0);
        idle();

        // x0 destination retires without writing
        step(0, 5'd0, 32'd0, 1, 5'd0, 32'h99, 0);
        chk("x0_valid", 64'(wb_valid), 64'd1);
        chk("x0_we", 64'(wb_we), 64'd0);

        // Freeze with two queued entries and a mul arriving mid-freeze
        step(1, 5'd1, 32'h5001, 1, 5'd8, 32'h88, 0);
        step(1, 5'd2, 32'h5002, 1, 5'd9, 32'h99, 0);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1);
        chk("frz_no_pop", 64'(wb_valid), 64'd0);
        step(1, 5'd12, 32'hC0C0, 0, 5'd0, 32'd0, 1);
        chk("frz_mul_rd", 64'(wb_rd), 64'd12);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1);
        idle();
        chk("frz_drain0", 64'(wb_rd), 64'd8);
        idle();
        chk("frz_drain1", 64'(wb_rd), 64'd9);
        idle();

        // Backpressure and overflow: mul busy, ALU pushing every cycle
        for (int i = 0; i < 5; i++) begin
            step(1, 5'(i + 20), $urandom, 1, 5'(i + 13), $urandom, 0);
            if (i == 2) chk("stall_at_3", 64'(alu_stall), 64'd1);
        end
        chk("ovf_set", 64'(ovf_err), 64'd1);

        // Reset mid-drain with two entries still queued
        idle();
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        mul_we = 1'b0; alu_we = 1'b0; freeze = 1'b0;
        #1;
        check_all_zero("mid_reset");
        q.delete();
        e_ovf = 1'b0; e_stall = 1'b0; e_valid = 1'b0; e_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) idle();

        // Random traffic; ALU issue honours the stall as upstream would
        for (int i = 0; i < 400; i++) begin
            bit av;
            av = !e_stall && ($urandom_range(2) != 0);
            step($urandom_range(1), 5'($urandom_range(7)), $urandom,
                 av, 5'($urandom_range(7)), $urandom,
                 $urandom_range(4) == 0);
        end
        for (int i = 0; i < DEPTH + 2; i++) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
